rom_stream_reader: RTL and testbench

//   Sequencer placed directly upstream of the combinational rom (4-bit addr, 8-bit dout).
//   On a start command it walks a contiguous address range and drives rom addr.
//   It captures each rom dout word into an output register.

---
 rtl/rom_stream_reader_if.sv | 12 +
 rtl/rom_stream_reader.sv | 100 ++++++++++
 tb/tb_rom_stream_reader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_if.sv
// Valid/ready stream carrying ROM words with a last-beat flag.
interface rom_stream_reader_if #(
    parameter int DATA_W = 8
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/rom_stream_reader.sv
// Walks a contiguous ROM address range on command and streams each word out
// through a single output register with valid/ready backpressure.
module rom_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_dout,
    rom_stream_reader_if.master m
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                xfer, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    assign xfer = valid_q && m.m_ready;
    // The output register refills on the same edge it drains, so a held-high
    // ready gives one word per cycle.
    assign load = (state_q == STREAM) && (remaining_q != '0) && (!valid_q || xfer);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d      = start_addr;
                        remaining_d = length;
                        state_d     = STREAM;
                    end else begin
                        state_d     = DONE;
                    end
                end
            end
            STREAM: begin
                if (load) begin
                    data_d      = rom_dout;
                    last_d      = (remaining_q == (ADDR_W+1)'(1));
                    valid_d     = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end else if (xfer) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rom_addr  = addr_q;
    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;
    assign m.m_last  = last_q;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: behavioural ROM plus a queue of expected words
// built from start address and length with modular address arithmetic.
module tb_rom_stream_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] length;
    logic       busy, done;
    logic [3:0] rom_addr;
    logic [7:0] rom_dout;
    logic [7:0] rom_mem [16];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    rom_stream_reader_if #(.DATA_W(8)) s_if ();

    assign rom_dout = rom_mem[rom_addr];

    rom_stream_reader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .length(length), .busy(busy), .done(done), .rom_addr(rom_addr),
        .rom_dout(rom_dout), .m(s_if.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        case (mode)
            0:       return 1'b1;
            1:       return pat[k % 6];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_burst(input logic [3:0] sa, input logic [4:0] len,
                             input int mode, input bit poke);
        logic [7:0] q [$];
        bit         started;
        for (int i = 0; i < int'(len); i++) q.push_back(rom_mem[(int'(sa) + i) % 16]);
        @(negedge clk);
        start = 1'b1; start_addr = sa; length = len; s_if.m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        if (len == 5'd0) begin
            chk("zero_busy", busy, 1);
            chk("zero_done", done, 1);
            chk("zero_valid", s_if.m_valid, 0);
            @(negedge clk); #1;
            chk("zero_idle_busy", busy, 0);
            chk("zero_idle_done", done, 0);
            return;
        end
        chk("lat_busy", busy, 1);
        chk("lat_valid0", s_if.m_valid, 0);
        started = 1'b0;
        for (int k = 0; k < 400 && q.size() != 0; k++) begin
            @(negedge clk);
            s_if.m_ready = ready_for(mode, k);
            if (poke && k == 2) begin
                start = 1'b1; start_addr = sa + 4'd7; length = 5'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (k == 0) chk("lat_valid1", s_if.m_valid, 1);
            chk("done_early", done, 0);
            if (mode == 0 && started) chk("bubble", s_if.m_valid, 1);
            if (s_if.m_valid) begin
                started = 1'b1;
                chk("data", s_if.m_data, q[0]);
                chk("last", s_if.m_last, 32'(q.size() == 1));
                if (s_if.m_ready) void'(q.pop_front());
            end
        end
        start = 1'b0;
        chk("beats_left", q.size(), 0);
        if (q.size() != 0) return;
        @(negedge clk); #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", s_if.m_valid, 0);
        chk("done_last", s_if.m_last, 0);
        @(negedge clk); #1;
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int seed;
        seed = int'($urandom);
        for (int i = 0; i < 16; i++) rom_mem[i] = 8'(i * 37 + seed);
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; s_if.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", s_if.m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", s_if.m_data, 0);
        chk("rst_last", s_if.m_last, 0);
        chk("rst_addr", rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_burst(4'd0,  5'd8,  0, 1'b0);
        run_burst(4'd2,  5'd5,  1, 1'b0);
        run_burst(4'd14, 5'd4,  0, 1'b0);
        run_burst(4'd14, 5'd4,  1, 1'b0);
        run_burst(4'd9,  5'd0,  0, 1'b0);
        run_burst(4'd5,  5'd16, 0, 1'b0);
        run_burst(4'd3,  5'd6,  0, 1'b1);
        for (int r = 0; r < 6; r++)
            run_burst(4'($urandom_range(0, 15)), 5'($urandom_range(1, 16)), 2, 1'b0);

        // Abandon a burst with an asynchronous reset between clock edges.
        @(negedge clk);
        start = 1'b1; start_addr = 4'd3; length = 5'd10;
        @(negedge clk);
        start = 1'b0; s_if.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_valid_pre", s_if.m_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", s_if.m_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_data", s_if.m_data, 0);
        chk("mid_last", s_if.m_last, 0);
        chk("mid_addr", rom_addr, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("mid_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        run_burst(4'd11, 5'd7, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
